// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch stage
package ifetch_pkg;

    localparam int IMEM_AW      = 6;
    localparam int INSTR_W      = 16;
    localparam int IFETCH_DEPTH = 2;
    localparam int IFETCH_CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [IMEM_AW-1:0] pc;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - 2-entry synchronous buffer of fetched {instr, pc} words
//
// Ports:
//   clk_main, reset : clock, asynchronous active-high reset
//   push, push_data : write one entry
//   pop             : retire the head entry
//   clear           : discard all entries (branch flush)
//   head            : head-of-buffer entry
//   count           : number of valid entries (0..2)
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  logic                    clk_main,
    input  logic                    reset,
    input  logic                    push,
    input  ifetch_entry_t           push_data,
    input  logic                    pop,
    input  logic                    clear,
    output ifetch_entry_t           head,
    output logic [IFETCH_CNT_W-1:0] count
);

    ifetch_entry_t mem [IFETCH_DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          full;

    assign full = (count == IFETCH_CNT_W'(IFETCH_DEPTH));
    assign head = mem[rd_ptr];

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IFETCH_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (clear) begin
            // Storage is left as is; contents are meaningless once count is 0.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + IFETCH_CNT_W'(push) - IFETCH_CNT_W'(pop);
        end
    end

    // The fetch credit rule guarantees a slot for every issued read.
    a_no_overflow: assert property (@(posedge clk_main) disable iff (reset)
        !(push && !pop && !clear && full));

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC advance control, ROM read, decoder handshake
//
// Optional feature macro: IFETCH_STALL_CNT_EN adds stall_cnt[7:0].
//
// Ports:
//   clk_main, reset   : clock, asynchronous active-high reset
//   pc                : current program counter
//   pc_inc            : fetch issued; control unit selects PC+1 this cycle
//   flush             : taken branch/jump, pc is being reloaded
//   halt_req          : stop issuing new fetches
//   imem_en/imem_addr : synchronous ROM read port, data returns next cycle
//   imem_rdata        : ROM read data
//   instr, instr_pc   : head-of-buffer word and its fetch address
//   instr_valid       : buffer non-empty
//   instr_ready       : decoder accepts the head this cycle
//   stall_cnt         : saturating count of RUN cycles without issue or flush
module instr_fetch
    import ifetch_pkg::*;
(
    input  logic               clk_main,
    input  logic               reset,
    input  logic [IMEM_AW-1:0] pc,
    output logic               pc_inc,
    input  logic               flush,
    input  logic               halt_req,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [IMEM_AW-1:0] instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [7:0]         stall_cnt
`endif
);

    ifetch_state_e           state;
    ifetch_state_e           state_nxt;
    logic                    inflight;
    logic [IMEM_AW-1:0]      req_pc;
    logic [IFETCH_CNT_W-1:0] count;
    logic [2:0]              occupancy;
    logic                    pop;
    logic                    push;
    logic                    issue;
    ifetch_entry_t           push_entry;
    ifetch_entry_t           head;

    // State register
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; flush never changes state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_RUN;
            S_RUN:   if (halt_req)  state_nxt = S_HALT;
            S_HALT:  if (!halt_req) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Slots already promised (buffered + returning), less the one leaving now.
    // pop implies count >= 1, so this never underflows.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    // Outputs
    always_comb begin
        issue = 1'b0;
        if (state == S_RUN && !halt_req && !flush && occupancy < 3'd2) begin
            issue = 1'b1;
        end
    end

    assign pc_inc    = issue;
    assign imem_en   = issue;
    assign imem_addr = pc;

    assign pop  = instr_valid & instr_ready;
    // A flush drops the word that is returning from the ROM this cycle.
    assign push = inflight & ~flush;

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            req_pc   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc <= pc;
            end
        end
    end

    assign push_entry = '{instr: imem_rdata, pc: req_pc};

    ifetch_fifo u_fifo (
        .clk_main  (clk_main),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (flush),
        .head      (head),
        .count     (count)
    );

    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_valid = (count != '0);

`ifdef IFETCH_STALL_CNT_EN
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == S_RUN && !issue && !flush && stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk_main = 1'b0;
    logic        reset;
    logic [5:0]  pc;
    logic        pc_inc;
    logic        flush;
    logic        halt_req;
    logic        imem_en;
    logic [5:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [5:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef IFETCH_STALL_CNT_EN
    logic [7:0]  stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Values sampled at the falling edge of the current cycle
    logic [31:0] s_inc, s_en, s_addr, s_valid, s_instr, s_pc;
    logic [5:0]  exp_pc;
    logic [5:0]  flush_pc;
    int          pops;
    int          incs;
    int          p0;
    int          cyc;
    int          first_inc;
    int          first_valid;

    always #5 clk_main = ~clk_main;

    instr_fetch dut (
        .clk_main    (clk_main),
        .reset       (reset),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .flush       (flush),
        .halt_req    (halt_req),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, score any pop, then after the
    // rising edge update the ROM model and the PC model.
    task automatic cycle();
        @(negedge clk_main);
        s_inc   = 32'(pc_inc);
        s_en    = 32'(imem_en);
        s_addr  = 32'(imem_addr);
        s_valid = 32'(instr_valid);
        s_instr = 32'(instr);
        s_pc    = 32'(instr_pc);
        if (instr_valid && instr_ready) begin
            check("pop_instr", s_instr, 32'h0000A000 + 32'(exp_pc));
            check("pop_pc", s_pc, 32'(exp_pc));
            exp_pc = exp_pc + 6'd1;
            pops++;
        end
        @(posedge clk_main);
        #1;
        if (s_en == 32'd1) imem_rdata = 16'hA000 + {10'd0, s_addr[5:0]};
        if (flush) begin
            pc     = flush_pc;
            exp_pc = flush_pc;
        end else if (s_inc == 32'd1) begin
            pc = pc + 6'd1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pc    = 6'd0;
        @(posedge clk_main);
        #1;
        reset  = 1'b0;
        exp_pc = 6'd0;
        cyc    = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        pc          = 6'd5;
        flush       = 1'b0;
        halt_req    = 1'b0;
        instr_ready = 1'b1;
        imem_rdata  = 16'h0000;
        flush_pc    = 6'd40;
        exp_pc      = 6'd0;
        pops        = 0;
        cyc         = 0;

        // Reset state
        #12;
        check("rst_pc_inc", 32'(pc_inc), 32'd0);
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd5);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        pc = 6'd0;
        @(posedge clk_main);
        #1;
        reset = 1'b0;

        // Streaming with ready high
        first_inc   = -1;
        first_valid = -1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (s_inc == 32'd1 && first_inc < 0) first_inc = cyc - 1;
            if (s_valid == 32'd1 && first_valid < 0) first_valid = cyc - 1;
        end
        check("first_issue_cycle", 32'(first_inc), 32'd1);
        check("first_valid_cycle", 32'(first_valid), 32'd3);
        check("stream_pops", 32'(pops), 32'd11);

        // Ready low from start: exactly two fetches, head held
        do_reset();
        instr_ready = 1'b0;
        incs = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            incs += int'(s_inc);
        end
        check("backpressure_issues", 32'(incs), 32'd2);
        check("held_valid", s_valid, 32'd1);
        check("held_instr", s_instr, 32'h0000A000);
        check("held_pc", s_pc, 32'd0);
        instr_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 6; i++) cycle();
        check("resume_pops", 32'(pops - p0), 32'd6);

        // Flush while streaming (word in flight dropped, pop honoured)
        flush_pc = 6'd40;
        flush = 1'b1;
        p0 = pops;
        cycle();
        check("flush_no_issue", s_inc, 32'd0);
        check("flush_stream_pop", 32'(pops - p0), 32'd1);
        flush = 1'b0;
        cycle();
        check("flush_valid_drop", s_valid, 32'd0);
        check("flush_refetch", s_inc, 32'd1);
        check("flush_refetch_addr", s_addr, 32'd40);
        cycle();
        check("flush_valid_f2", s_valid, 32'd0);
        cycle();
        check("flush_valid_f3", s_valid, 32'd1);
        check("flush_instr_f3", s_instr, 32'h0000A028);
        check("flush_pc_f3", s_pc, 32'd40);

        // Flush coincident with pop on a full buffer
        do_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        check("full_valid", s_valid, 32'd1);
        instr_ready = 1'b1;
        flush_pc = 6'd40;
        flush = 1'b1;
        p0 = pops;
        cycle();
        check("flush_pop_once", 32'(pops - p0), 32'd1);
        flush = 1'b0;
        cycle();
        check("flush_pop_empty", s_valid, 32'd0);
        cycle();
        cycle();
        check("flush_pop_next", s_instr, 32'h0000A028);
        for (int i = 0; i < 4; i++) cycle();

        // Halt while streaming
        halt_req = 1'b1;
        incs = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            incs += int'(s_inc);
        end
        check("halt_no_issue", 32'(incs), 32'd0);
        check("halt_drained", s_valid, 32'd0);
        halt_req = 1'b0;
        cycle();
        check("halt_release_wait", s_inc, 32'd0);
        cycle();
        check("halt_resume", s_inc, 32'd1);
        p0 = pops;
        for (int i = 0; i < 6; i++) cycle();
        check("halt_after_pops", 32'(pops - p0), 32'd5);

        // Asynchronous reset mid-cycle
        #3;
        reset = 1'b1;
        pc    = 6'd0;
        #1;
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_pc_inc", 32'(pc_inc), 32'd0);
        check("async_imem_en", 32'(imem_en), 32'd0);
        check("async_instr", 32'(instr), 32'd0);
        @(posedge clk_main);
        #1;
        reset  = 1'b0;
        exp_pc = 6'd0;
        cyc    = 0;
        p0 = pops;
        for (int i = 0; i < 6; i++) cycle();
        check("restart_pops", 32'(pops - p0), 32'd3);

`ifdef IFETCH_STALL_CNT_EN
        do_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("stall_cnt_10", 32'(stall_cnt), 32'd7);
        for (int i = 0; i < 300; i++) cycle();
        check("stall_cnt_sat", 32'(stall_cnt), 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
